// File: rtl/operand_capture_if.sv
// operand_capture_if
//   Bundles the user-entry inputs and committed operand outputs of
//   operand_capture. Clock and reset stay as plain ports on the module.
//
//   Signals:
//     iKEY_N  raw active-low pushbutton (asynchronous, bouncy)
//     iSW     operand value, sampled on presses 1 and 2
//     iSEL    operation selector, sampled on press 3
//     oA/oB   committed operands
//     oSEL    committed selector
//     oVALID  sticky "a full set has been committed"
//     oUPDATE one-cycle pulse after a commit
//     oPRESS  one-cycle pulse after each accepted press
//     oSTAGE  entry state (0 WAIT_A, 1 WAIT_B, 2 WAIT_OP)
//
//   Modports: slave = operand_capture, master = whatever drives it.
//   W must match the W parameter of the attached operand_capture.
interface operand_capture_if #(
    parameter int W = 4
);
    logic         iKEY_N;
    logic [W-1:0] iSW;
    logic [1:0]   iSEL;
    logic [W-1:0] oA;
    logic [W-1:0] oB;
    logic [1:0]   oSEL;
    logic         oVALID;
    logic         oUPDATE;
    logic         oPRESS;
    logic [1:0]   oSTAGE;

    modport slave (
        input  iKEY_N, iSW, iSEL,
        output oA, oB, oSEL, oVALID, oUPDATE, oPRESS, oSTAGE
    );

    modport master (
        output iKEY_N, iSW, iSEL,
        input  oA, oB, oSEL, oVALID, oUPDATE, oPRESS, oSTAGE
    );
endinterface

// File: rtl/operand_capture.sv
// operand_capture
//   Button-driven operand entry for the downstream adder. Press 1 stages A
//   from iSW, press 2 stages B from iSW, press 3 samples iSEL and commits
//   A/B/SEL together, so the adder never sees a half-updated operand set.
//
//   Ports:
//     iCLK    system clock
//     iRST_N  asynchronous active-low reset, clears all state
//     bus     operand_capture_if.slave (key, switches, selector, outputs)
//
//   Build option:
//     OPERAND_CAPTURE_DEBOUNCE_EN  defined: key level changes need
//       DEBOUNCE_CYCLES consecutive stable synchronized samples.
//       Undefined: the synchronized key is used directly (no filtering).
//
//   state   | meaning
//   --------+---------------------------------------------
//   WAIT_A  | next press stages operand A
//   WAIT_B  | next press stages operand B
//   WAIT_OP | next press samples selector and commits all
module operand_capture #(
    parameter int W               = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    operand_capture_if.slave   bus
);

    localparam logic [1:0] WAIT_A  = 2'd0;
    localparam logic [1:0] WAIT_B  = 2'd1;
    localparam logic [1:0] WAIT_OP = 2'd2;

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("operand_capture: DEBOUNCE_CYCLES must be >= 2");
    end

    // ------------------------------------------------------------------
    // Key synchronizer and debounce
    // ------------------------------------------------------------------
    logic k_s1_q, k_s1_d;
    logic k_s2_q, k_s2_d;
    logic stable_q, stable_d;
    logic press;

    always_comb begin
        k_s1_d = bus.iKEY_N;
        k_s2_d = k_s1_q;
    end

`ifdef OPERAND_CAPTURE_DEBOUNCE_EN
    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Any sample agreeing with the accepted level restarts the run, so
    // only an uninterrupted run of opposite samples flips stable.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (k_s2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = k_s2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    always_comb begin
        stable_d = k_s2_q;
    end
`endif

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            k_s1_q   <= 1'b1;
            k_s2_q   <= 1'b1;
            stable_q <= 1'b1;
        end else begin
            k_s1_q   <= k_s1_d;
            k_s2_q   <= k_s2_d;
            stable_q <= stable_d;
        end
    end

    // Press is the edge where the accepted level falls; a held key stays
    // low and cannot fall again until a release has been accepted.
    assign press = stable_q & ~stable_d;

    // ------------------------------------------------------------------
    // Entry FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    logic [1:0] state_q, state_d;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= WAIT_A;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (press) begin
            case (state_q)
                WAIT_A:  state_d = WAIT_B;
                WAIT_B:  state_d = WAIT_OP;
                WAIT_OP: state_d = WAIT_A;
                default: state_d = WAIT_A;
            endcase
        end
    end

    logic [W-1:0] stg_a_q, stg_a_d;
    logic [W-1:0] stg_b_q, stg_b_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic [1:0]   sel_q, sel_d;
    logic         valid_q, valid_d;
    logic         update_q, update_d;
    logic         press_q, press_d;

    always_comb begin
        stg_a_d  = stg_a_q;
        stg_b_d  = stg_b_q;
        a_d      = a_q;
        b_d      = b_q;
        sel_d    = sel_q;
        valid_d  = valid_q;
        update_d = 1'b0;
        press_d  = press;
        if (press) begin
            case (state_q)
                WAIT_A: stg_a_d = bus.iSW;
                WAIT_B: stg_b_d = bus.iSW;
                WAIT_OP: begin
                    a_d      = stg_a_q;
                    b_d      = stg_b_q;
                    sel_d    = bus.iSEL;
                    valid_d  = 1'b1;
                    update_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            stg_a_q  <= '0;
            stg_b_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= '0;
            valid_q  <= 1'b0;
            update_q <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            stg_a_q  <= stg_a_d;
            stg_b_q  <= stg_b_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sel_q    <= sel_d;
            valid_q  <= valid_d;
            update_q <= update_d;
            press_q  <= press_d;
        end
    end

    assign bus.oA      = a_q;
    assign bus.oB      = b_q;
    assign bus.oSEL    = sel_q;
    assign bus.oVALID  = valid_q;
    assign bus.oUPDATE = update_q;
    assign bus.oPRESS  = press_q;
    assign bus.oSTAGE  = state_q;

endmodule

// File: tb/tb_operand_capture.sv
// tb_operand_capture
//   Self-checking bench for operand_capture. A small behavioural model
//   (entry step counter, staged values, committed values) predicts every
//   output; press timing is derived from the key waveform and the build's
//   filter latency.
module tb_operand_capture;

    localparam int W  = 4;
    localparam int DB = 4;
`ifdef OPERAND_CAPTURE_DEBOUNCE_EN
    localparam int LAT = 1 + DB;   // negedges after key fall until oPRESS seen
`else
    localparam int LAT = 2;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    operand_capture_if #(.W(W)) bus ();

    operand_capture #(
        .W               (W),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .iCLK   (clk),
        .iRST_N (rst_n),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // behavioural model
    int           m_step;   // presses since last commit, 0..2
    logic [W-1:0] m_stga, m_stgb, m_a, m_b;
    logic [1:0]   m_sel;
    logic         m_valid;

    task automatic model_reset();
        m_step = 0; m_stga = '0; m_stgb = '0;
        m_a = '0; m_b = '0; m_sel = '0; m_valid = 1'b0;
    endtask

    task automatic model_press(input logic [W-1:0] sw, input logic [1:0] sel,
                               output bit commit);
        commit = 0;
        if (m_step == 0) m_stga = sw;
        else if (m_step == 1) m_stgb = sw;
        else begin
            m_a = m_stga; m_b = m_stgb; m_sel = sel; m_valid = 1'b1; commit = 1;
        end
        m_step = (m_step + 1) % 3;
    endtask

    // Clean press: key falls, held long enough, then released. Every cycle
    // all outputs are compared with the model.
    task automatic do_press(input logic [W-1:0] sw, input logic [1:0] sel,
                            input string tag);
        bit commit;
        bit exp_p, exp_u;
        @(negedge clk);
        bus.iSW = sw; bus.iSEL = sel; bus.iKEY_N = 1'b0;
        for (int k = 0; k < LAT + 3; k++) begin
            @(negedge clk);
            exp_p = 0; exp_u = 0;
            if (k == LAT) begin
                model_press(sw, sel, commit);
                exp_p = 1; exp_u = commit;
            end
            checks++;
            if (bus.oPRESS !== exp_p || bus.oUPDATE !== exp_u ||
                bus.oSTAGE !== 2'(m_step) || bus.oA !== m_a || bus.oB !== m_b ||
                bus.oSEL !== m_sel || bus.oVALID !== m_valid) begin
                errors++;
                $display("FAIL %s k=%0d: got press=%b upd=%b stage=%0d A=%h B=%h SEL=%0d V=%b, want press=%b upd=%b stage=%0d A=%h B=%h SEL=%0d V=%b",
                         tag, k, bus.oPRESS, bus.oUPDATE, bus.oSTAGE, bus.oA, bus.oB,
                         bus.oSEL, bus.oVALID, exp_p, exp_u, m_step, m_a, m_b, m_sel, m_valid);
            end
            if (k >= LAT) begin
                // switches moving outside the press edge must be ignored
                bus.iSW  = W'($urandom);
                bus.iSEL = 2'($urandom);
            end
        end
        bus.iKEY_N = 1'b1;
        for (int k = 0; k < LAT + 3; k++) begin
            @(negedge clk);
            checks++;
            if (bus.oPRESS !== 1'b0 || bus.oUPDATE !== 1'b0 || bus.oSTAGE !== 2'(m_step)) begin
                errors++;
                $display("FAIL %s_release k=%0d: got press=%b upd=%b stage=%0d, want 0 0 %0d",
                         tag, k, bus.oPRESS, bus.oUPDATE, bus.oSTAGE, m_step);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.iKEY_N = 1'($urandom); bus.iSW = W'($urandom); bus.iSEL = 2'($urandom);
            @(negedge clk);
            checks++;
            if ({bus.oA, bus.oB, bus.oSEL, bus.oVALID, bus.oUPDATE, bus.oPRESS, bus.oSTAGE} !== '0) begin
                errors++;
                $display("FAIL reset_hold: got A=%h B=%h SEL=%0d V=%b U=%b P=%b ST=%0d, want all 0",
                         bus.oA, bus.oB, bus.oSEL, bus.oVALID, bus.oUPDATE, bus.oPRESS, bus.oSTAGE);
            end
        end
        bus.iKEY_N = 1'b1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.oA, bus.oB, bus.oSEL, bus.oVALID, bus.oUPDATE, bus.oPRESS, bus.oSTAGE} !== '0) begin
                errors++;
                $display("FAIL reset_release: got A=%h B=%h SEL=%0d V=%b U=%b P=%b ST=%0d, want all 0",
                         bus.oA, bus.oB, bus.oSEL, bus.oVALID, bus.oUPDATE, bus.oPRESS, bus.oSTAGE);
            end
        end
    endtask

    task automatic test_full_sequence();
        do_press(4'h3, 2'($urandom), "seq_p1");
        do_press(4'h5, 2'($urandom), "seq_p2");
        do_press(W'($urandom), 2'b10, "seq_p3");
        checks++;
        if (bus.oA !== 4'h3 || bus.oB !== 4'h5 || bus.oSEL !== 2'b10 || bus.oVALID !== 1'b1) begin
            errors++;
            $display("FAIL seq_result: got A=%h B=%h SEL=%0d V=%b, want 3 5 2 1",
                     bus.oA, bus.oB, bus.oSEL, bus.oVALID);
        end
    endtask

    task automatic test_stability();
        do_press(4'hF, 2'($urandom), "stab_p1");
        do_press(4'hE, 2'($urandom), "stab_p2");
        checks++;
        if (bus.oA !== 4'h3 || bus.oB !== 4'h5) begin
            errors++;
            $display("FAIL stab_hold: got A=%h B=%h, want 3 5", bus.oA, bus.oB);
        end
        do_press(W'($urandom), 2'b01, "stab_p3");
        checks++;
        if (bus.oA !== 4'hF || bus.oB !== 4'hE || bus.oSEL !== 2'b01) begin
            errors++;
            $display("FAIL stab_commit: got A=%h B=%h SEL=%0d, want F E 1", bus.oA, bus.oB, bus.oSEL);
        end
    endtask

    task automatic test_random_sequences();
        for (int n = 0; n < 6; n++) begin
            do_press(W'($urandom), 2'($urandom), "rand");
        end
    endtask

    // Short low pulse: rejected by the filter; accepted raw without it.
    task automatic test_glitch();
        int npress = 0;
        int st0;
        bit commit;
        logic [W-1:0] sw;
        st0 = m_step;
        sw = W'($urandom);
        @(negedge clk);
        bus.iSW = sw;
`ifdef OPERAND_CAPTURE_DEBOUNCE_EN
        bus.iKEY_N = 1'b0;
        repeat (3) @(negedge clk);
        bus.iKEY_N = 1'b1;
`else
        bus.iKEY_N = 1'b0;
        @(negedge clk);
        bus.iKEY_N = 1'b1;
`endif
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.oPRESS === 1'b1) npress++;
        end
`ifdef OPERAND_CAPTURE_DEBOUNCE_EN
        checks++;
        if (npress != 0 || bus.oSTAGE !== 2'(st0)) begin
            errors++;
            $display("FAIL glitch: got presses=%0d stage=%0d, want 0 %0d", npress, bus.oSTAGE, st0);
        end
`else
        model_press(sw, bus.iSEL, commit);
        checks++;
        if (npress != 1 || bus.oSTAGE !== 2'(m_step)) begin
            errors++;
            $display("FAIL glitch_raw: got presses=%0d stage=%0d, want 1 %0d", npress, bus.oSTAGE, m_step);
        end
`endif
    endtask

    // Key held for a long time: exactly one press, no auto-repeat.
    // With the filter, a bouncy lead-in is added before the hold.
    task automatic test_held_and_bounce(input bit bouncy, input string tag);
        int npress = 0;
        bit commit;
        logic [W-1:0] sw;
        sw = W'($urandom);
        @(negedge clk);
        bus.iSW = sw;
        for (int c = 0; c < 40; c++) begin
            if (c > 0 && bus.oPRESS === 1'b1) npress++;
            bus.iKEY_N = (bouncy && c < 10) ? 1'(c % 2) : 1'b0;
            @(negedge clk);
        end
        if (bus.oPRESS === 1'b1) npress++;
        model_press(sw, bus.iSEL, commit);
        checks++;
        if (npress != 1 || bus.oSTAGE !== 2'(m_step)) begin
            errors++;
            $display("FAIL %s: got presses=%0d stage=%0d, want 1 %0d", tag, npress, bus.oSTAGE, m_step);
        end
        bus.iKEY_N = 1'b1;
        npress = 0;
        for (int c = 0; c < LAT + 4; c++) begin
            @(negedge clk);
            if (bus.oPRESS === 1'b1) npress++;
        end
        checks++;
        if (npress != 0) begin
            errors++;
            $display("FAIL %s_release: got presses=%0d, want 0", tag, npress);
        end
    endtask

    task automatic test_reset_mid_sequence();
        // realign to WAIT_A, then advance to WAIT_OP
        while (m_step != 0) do_press(W'($urandom), 2'($urandom), "mid_align");
        do_press(W'($urandom), 2'($urandom), "mid_p1");
        do_press(W'($urandom), 2'($urandom), "mid_p2");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.oSTAGE !== 2'd0 || bus.oVALID !== 1'b0 || bus.oA !== '0 ||
            bus.oB !== '0 || bus.oSEL !== 2'd0) begin
            errors++;
            $display("FAIL mid_reset_async: got ST=%0d V=%b A=%h B=%h SEL=%0d, want all 0",
                     bus.oSTAGE, bus.oVALID, bus.oA, bus.oB, bus.oSEL);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        do_press(4'h9, 2'($urandom), "mid_fresh_a");
        do_press(4'h6, 2'($urandom), "mid_fresh_b");
        do_press(W'($urandom), 2'b11, "mid_fresh_op");
        checks++;
        if (bus.oA !== 4'h9 || bus.oB !== 4'h6 || bus.oSEL !== 2'b11 || bus.oVALID !== 1'b1) begin
            errors++;
            $display("FAIL mid_fresh_commit: got A=%h B=%h SEL=%0d V=%b, want 9 6 3 1",
                     bus.oA, bus.oB, bus.oSEL, bus.oVALID);
        end
    endtask

    initial begin
        bus.iKEY_N = 1'b1;
        bus.iSW    = '0;
        bus.iSEL   = '0;
        model_reset();
        test_reset();
        test_full_sequence();
        test_stability();
        test_glitch();
        test_held_and_bounce(1'b0, "held");
`ifdef OPERAND_CAPTURE_DEBOUNCE_EN
        test_held_and_bounce(1'b1, "bounce");
`endif
        test_random_sequences();
        test_reset_mid_sequence();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule
